// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory_bus port between a CPU (port 0) and a
// DMA/blitter (port 1). Each access is latched at grant and sequenced
// IDLE -> ACCESS -> DONE. The owner gets a one-cycle ack. A watchdog aborts
// accesses that are stuck on bus_halt.
// Optional statistics counters are enabled by defining MEM_BUS_ARBITER_STATS_EN.
module mem_bus_arbiter #(
    parameter int ACCESS_CYCLES  = 2,
    parameter int TIMEOUT        = 4096,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic [23:0] address_0,
    input  logic [7:0]  data_in_0,
    input  logic        write_enable_0,
    output logic [7:0]  data_out_0,
    output logic        ack_0,
    output logic        error_0,
    input  logic        req_1,
    input  logic [23:0] address_1,
    input  logic [7:0]  data_in_1,
    input  logic        write_enable_1,
    output logic [7:0]  data_out_1,
    output logic        ack_1,
    output logic        error_1,
    output logic [23:0] address,
    output logic [7:0]  data_in,
    output logic        write_enable,
    output logic        bus_enable,
    input  logic [7:0]  bus_data_out,
    input  logic        bus_halt,
    output logic [1:0]  grant
`ifdef MEM_BUS_ARBITER_STATS_EN
    ,
    input  logic        stats_clear,
    output logic [15:0] grant_count_0,
    output logic [15:0] grant_count_1,
    output logic [15:0] halt_cycles,
    output logic [7:0]  timeouts
`endif
);

    localparam int CYC_W  = $clog2(ACCESS_CYCLES) + 1;
    localparam int HALT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CYC_W-1:0]  CYC_LIM  = CYC_W'(ACCESS_CYCLES - 1);
    localparam logic [HALT_W-1:0] HALT_LIM = HALT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]        r_state;
    logic              r_owner;       // 0 = port 0, 1 = port 1
    logic              r_last_grant;
    logic [CYC_W-1:0]  r_cyc_cnt;
    logic [HALT_W-1:0] r_halt_cnt;
    logic [23:0]       r_address;
    logic [7:0]        r_data_in;
    logic              r_write_enable;
    logic              r_bus_enable;
    logic [1:0]        r_grant;
    logic [7:0]        r_data_out_0;
    logic [7:0]        r_data_out_1;
    logic              r_ack_0;
    logic              r_ack_1;
    logic              r_error_0;
    logic              r_error_1;

    logic w_any_req;
    logic w_pick_1;
    logic w_done_ok;
    logic w_timeout;

    // Winner selection: port 1 wins when it is alone, or on a conflict when
    // round-robin is in use and port 0 was the last owner.
    always_comb begin
        w_any_req = req_0 | req_1;
        w_pick_1  = req_1 & (~req_0 | ((FIXED_PRIORITY == 0) & ~r_last_grant));
        w_done_ok = (r_cyc_cnt >= CYC_LIM) & ~bus_halt;
        w_timeout = bus_halt & (r_halt_cnt >= HALT_LIM);
    end

    // Access sequencer. All bus-facing outputs are registered and latched at grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_last_grant   <= 1'b1;
            r_cyc_cnt      <= '0;
            r_halt_cnt     <= '0;
            r_address      <= '0;
            r_data_in      <= '0;
            r_write_enable <= 1'b0;
            r_bus_enable   <= 1'b0;
            r_grant        <= 2'b00;
            r_data_out_0   <= '0;
            r_data_out_1   <= '0;
            r_ack_0        <= 1'b0;
            r_ack_1        <= 1'b0;
            r_error_0      <= 1'b0;
            r_error_1      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner        <= w_pick_1;
                        r_address      <= w_pick_1 ? address_1      : address_0;
                        r_data_in      <= w_pick_1 ? data_in_1      : data_in_0;
                        r_write_enable <= w_pick_1 ? write_enable_1 : write_enable_0;
                        r_grant        <= w_pick_1 ? 2'b10 : 2'b01;
                        r_bus_enable   <= 1'b1;
                        r_cyc_cnt      <= '0;
                        r_halt_cnt     <= '0;
                        r_state        <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cyc_cnt != '1)
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    if (bus_halt) begin
                        if (r_halt_cnt != '1)
                            r_halt_cnt <= r_halt_cnt + 1'b1;
                    end else begin
                        r_halt_cnt <= '0;
                    end
                    if (w_timeout || w_done_ok) begin
                        if (w_timeout) begin
                            if (r_owner) begin
                                r_data_out_1 <= 8'hFF;
                                r_error_1    <= 1'b1;
                            end else begin
                                r_data_out_0 <= 8'hFF;
                                r_error_0    <= 1'b1;
                            end
                        end else if (!r_write_enable) begin
                            if (r_owner) r_data_out_1 <= bus_data_out;
                            else         r_data_out_0 <= bus_data_out;
                        end
                        r_ack_0        <= ~r_owner;
                        r_ack_1        <= r_owner;
                        r_bus_enable   <= 1'b0;
                        r_write_enable <= 1'b0;
                        r_grant        <= 2'b00;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ack_0      <= 1'b0;
                    r_ack_1      <= 1'b0;
                    r_error_0    <= 1'b0;
                    r_error_1    <= 1'b0;
                    r_last_grant <= r_owner;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign address      = r_address;
    assign data_in      = r_data_in;
    assign write_enable = r_write_enable;
    assign bus_enable   = r_bus_enable;
    assign grant        = r_grant;
    assign data_out_0   = r_data_out_0;
    assign data_out_1   = r_data_out_1;
    assign ack_0        = r_ack_0;
    assign ack_1        = r_ack_1;
    assign error_0      = r_error_0;
    assign error_1      = r_error_1;

`ifdef MEM_BUS_ARBITER_STATS_EN
    logic [15:0] r_grant_count_0;
    logic [15:0] r_grant_count_1;
    logic [15:0] r_halt_cycles;
    logic [7:0]  r_timeouts;

    // Saturating statistics counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clear) begin
            r_grant_count_0 <= '0;
            r_grant_count_1 <= '0;
            r_halt_cycles   <= '0;
            r_timeouts      <= '0;
        end else begin
            if (r_state == S_DONE && !r_owner && r_grant_count_0 != '1)
                r_grant_count_0 <= r_grant_count_0 + 1'b1;
            if (r_state == S_DONE && r_owner && r_grant_count_1 != '1)
                r_grant_count_1 <= r_grant_count_1 + 1'b1;
            if (r_state == S_ACCESS && bus_halt && r_halt_cycles != '1)
                r_halt_cycles <= r_halt_cycles + 1'b1;
            if (r_state == S_ACCESS && w_timeout && r_timeouts != '1)
                r_timeouts <= r_timeouts + 1'b1;
        end
    end

    assign grant_count_0 = r_grant_count_0;
    assign grant_count_1 = r_grant_count_1;
    assign halt_cycles   = r_halt_cycles;
    assign timeouts      = r_timeouts;
`endif

endmodule
